// File: rtl/vram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_rd_arbiter
// Description : Three-requester read arbiter for one 32-bit VRAM read slot.
//               A request is issued combinationally in the cycle it is
//               picked. mem_ack returns one cycle later. A slot that is lost
//               to a higher-priority CPU access is re-presented
//               unchanged until it is accepted. Read data is passed through
//               in the ack cycle. After that it is held per requester.
//
// Ports       : clk, rst              - clock, synchronous active-high reset
//               prio_mode_i           - 0 round-robin, 1 fixed (0 > 1 > 2)
//               reqN_valid_i/addr_i   - request and word address, N = 0..2
//               reqN_ack_o            - one-cycle completion pulse
//               reqN_rddata_o         - read data (live on ack, held after)
//               mem_strobe_o/addr_o   - request to the VRAM read slot
//               mem_ack_i/rddata_i    - registered acceptance and read data
// Revision    : 1.0 - initial release
// ============================================================================
module vram_rd_arbiter #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prio_mode_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    output logic              req0_ack_o,
    output logic [31:0]       req0_rddata_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    output logic              req1_ack_o,
    output logic [31:0]       req1_rddata_o,
    input  logic              req2_valid_i,
    input  logic [ADDR_W-1:0] req2_addr_i,
    output logic              req2_ack_o,
    output logic [31:0]       req2_rddata_o,
    output logic              mem_strobe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rddata_i
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              in_flight_q, in_flight_d;
    logic [1:0]        cur_owner_q, cur_owner_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [1:0]        rr_ptr_q,    rr_ptr_d;
    logic [31:0]       hold_q [3];
    logic [31:0]       hold_d [3];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic              acc;
    logic              represent;
    logic [2:0]        valid;
    logic [2:0]        ack;
    logic [2:0]        elig;
    logic [1:0]        start;
    logic [1:0]        pick_idx;
    logic              pick_vld;
    logic [ADDR_W-1:0] pick_addr;

    assign valid = {req2_valid_i, req1_valid_i, req0_valid_i};

    // mem_ack only counts when a strobe was actually presented last cycle.
    assign acc       = in_flight_q & mem_ack_i & ~rst;
    assign represent = in_flight_q & ~mem_ack_i & ~rst;

    assign ack[0] = acc & (cur_owner_q == 2'd0);
    assign ack[1] = acc & (cur_owner_q == 2'd1);
    assign ack[2] = acc & (cur_owner_q == 2'd2);

    // The requester being acked still shows its old valid this cycle.
    assign elig = valid & ~ack;

    // Fixed priority always searches from 0. Round-robin searches from the
    // requester after the last grant.
    always_comb begin
        start = 2'd0;
        if (!prio_mode_i) begin
            start = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
        end
    end

    always_comb begin
        pick_idx = 2'd0;
        case (start)
            2'd1: begin
                if (elig[1])      pick_idx = 2'd1;
                else if (elig[2]) pick_idx = 2'd2;
                else              pick_idx = 2'd0;
            end
            2'd2: begin
                if (elig[2])      pick_idx = 2'd2;
                else if (elig[0]) pick_idx = 2'd0;
                else              pick_idx = 2'd1;
            end
            default: begin
                if (elig[0])      pick_idx = 2'd0;
                else if (elig[1]) pick_idx = 2'd1;
                else              pick_idx = 2'd2;
            end
        endcase
    end

    assign pick_vld = ~rst & ~represent & (|elig);

    always_comb begin
        case (pick_idx)
            2'd0:    pick_addr = req0_addr_i;
            2'd1:    pick_addr = req1_addr_i;
            default: pick_addr = req2_addr_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port
    // ------------------------------------------------------------------
    assign mem_strobe_o = represent | pick_vld;

    always_comb begin
        mem_addr_o = '0;
        if (represent) begin
            mem_addr_o = cur_addr_q;
        end else if (pick_vld) begin
            mem_addr_o = pick_addr;
        end
    end

    // ------------------------------------------------------------------
    // Requester outputs
    // ------------------------------------------------------------------
    assign req0_ack_o    = ack[0];
    assign req1_ack_o    = ack[1];
    assign req2_ack_o    = ack[2];
    assign req0_rddata_o = ack[0] ? mem_rddata_i : hold_q[0];
    assign req1_rddata_o = ack[1] ? mem_rddata_i : hold_q[1];
    assign req2_rddata_o = ack[2] ? mem_rddata_i : hold_q[2];

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        in_flight_d = mem_strobe_o;
        cur_owner_d = cur_owner_q;
        cur_addr_d  = cur_addr_q;
        rr_ptr_d    = rr_ptr_q;
        if (pick_vld) begin
            cur_owner_d = pick_idx;
            cur_addr_d  = pick_addr;
            rr_ptr_d    = pick_idx;
        end
        for (int i = 0; i < 3; i++) begin
            hold_d[i] = ack[i] ? mem_rddata_i : hold_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= 1'b0;
            cur_owner_q <= 2'd0;
            cur_addr_q  <= '0;
            rr_ptr_q    <= 2'd2;
            for (int i = 0; i < 3; i++) begin
                hold_q[i] <= 32'd0;
            end
        end else begin
            in_flight_q <= in_flight_d;
            cur_owner_q <= cur_owner_d;
            cur_addr_q  <= cur_addr_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int i = 0; i < 3; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

endmodule
`default_nettype wire
